vid_hcount: RTL and testbench
=============================

// Module: vid_hcount
// PURPOSE
//  11-bit video horizontal/pixel counter with programmable period and sync window.
//  Sits directly upstream of the 11-input AND terminal-count decode: its count bits
//  (true or inverted per compare value) drive that decode.
//  Also registers its own equality compares for period, hsync start and hsync end.
//  Produces a one-cycle line-end strobe (tc) and a registered hsync level for the
//  video timing chain.
// PARAMETERS
//  WIDTH      11      counter / compare register width (only 11 is supported)
//  PERIOD_RST 11'h7FF period register value after reset
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  resetl     in   1   asynchronous active-low reset
//  en         in   1   pixel enable; counter advances only when high
//  per_wr     in   1   write strobe for period register
//  hss_wr     in   1   write strobe for hsync-start register
//  hse_wr     in   1   write strobe for hsync-end register
//  wr_d       in   11  write data shared by the three strobes
//  count      out  11  current counter value
//  tc         out  1   one-cycle pulse, registered, on the period->0 transition
//  hsync      out  1   registered hsync level
// BEHAVIOUR
//  Reset (resetl low, async)
//   count=0, tc=0, hsync=0, period=PERIOD_RST, hss=0, hse=0.
//   Release is synchronous to the first clk edge.
//  Register writes
//   Each strobe loads wr_d into its register on the edge; the new value is used
//   from the next cycle.
//   Simultaneous strobes all load the same wr_d.
//  Counter
//   en=0: count, hsync hold; tc=0 the following cycle.
//   en=1 and count==period: count<=0, tc<=1 (tc asserted exactly one cycle).
//   en=1 otherwise: count<=count+1, tc<=0.
//   Compare is strict equality, no >= test. If period is written below the current
//   count, the counter runs to 11'h7FF and wraps to 0 without tc.
//   It then matches period on the next pass.
//   period=0 with en held high: count stays 0, tc high every cycle.
//  Hsync (evaluated only when en=1, on the pre-increment count)
//   count==hss -> hsync<=1
//   else count==hse -> hsync<=0
//   else hold
//   hss==hse: start wins, hsync stays 1 once set.
//   Matches at count==period behave as at any other value.
//  Latency
//   tc and hsync change on the same edge that loads the matched count+1 / 0,
//   i.e. one clk after the matching count is visible.
//  Reset mid-line
//   Counter and hsync clear immediately.
//   All compare registers are re-initialised, so software must rewrite them.
// TESTING
//  1 Reset, period=9, en=1 for 25 clk -> count 0..9,0..9,0..4; tc high on the
//    cycles count shows 0 after 9 (twice), low elsewhere.
//  2 period=9, hss=3, hse=6, en=1 -> hsync rises when count shows 4, falls when
//    count shows 7; repeats each line.
//  3 en toggled 1,0,0,1 at count=9 (period 9) -> count holds 9 through en=0,
//    wraps to 0 with single tc only after en returns high.
//  4 count=500, write period=100 -> count runs to 2047, wraps to 0 with tc=0,
//    then tc on the 100->0 transition.
//  5 hss=hse=5 -> hsync rises at count 6 and never falls; period=0, en=1 ->
//    count=0, tc constantly 1.
//  6 resetl pulsed low mid-line (async, between edges) -> count, tc, hsync 0
//    immediately; period reads back 11'h7FF behaviour (no tc until count 2047->0).

Source files
------------

// File: rtl/vid_hcount.sv
// 11-bit horizontal pixel counter with programmable period and hsync window.
// Emits a registered one-cycle line-end strobe and a registered hsync level.
module vid_hcount #(
  parameter int unsigned           WIDTH      = 11,
  parameter logic [WIDTH-1:0]      PERIOD_RST = 11'h7FF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             per_wr_i,
  input  logic             hss_wr_i,
  input  logic             hse_wr_i,
  input  logic [WIDTH-1:0] wr_d_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             hsync_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] hss_q, hss_d;
  logic [WIDTH-1:0] hse_q, hse_d;
  logic             tc_q, tc_d;
  logic             hsync_q, hsync_d;

  logic per_match, hss_match, hse_match;

  // Strict equality: a period written below the current count is only hit after wrap.
  assign per_match = (count_q == period_q);
  assign hss_match = (count_q == hss_q);
  assign hse_match = (count_q == hse_q);

  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    hsync_d  = hsync_q;
    period_d = per_wr_i ? wr_d_i : period_q;
    hss_d    = hss_wr_i ? wr_d_i : hss_q;
    hse_d    = hse_wr_i ? wr_d_i : hse_q;
    if (en_i) begin
      if (per_match) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
      // Start has priority so an empty window (hss == hse) latches high.
      if (hss_match) begin
        hsync_d = 1'b1;
      end else if (hse_match) begin
        hsync_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      hsync_q  <= 1'b0;
      period_q <= PERIOD_RST;
      hss_q    <= '0;
      hse_q    <= '0;
    end else begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      hsync_q  <= hsync_d;
      period_q <= period_d;
      hss_q    <= hss_d;
      hse_q    <= hse_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign hsync_o = hsync_q;

endmodule

// File: tb/tb_vid_hcount.sv
// Self-checking bench for vid_hcount: constant vector table, directed corner
// sequences and randomized traffic against an integer reference model.
module tb_vid_hcount;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        per_wr, hss_wr, hse_wr;
  logic [10:0] wr_d;
  logic [10:0] count;
  logic        tc;
  logic        hsync;

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers).
  int m_count, m_per, m_hss, m_hse, m_tc, m_hsync;

  typedef struct {
    logic        en;
    logic        per_wr;
    logic [10:0] wr_d;
    int          exp_count;
    int          exp_tc;
    int          exp_hsync;
  } vec_t;

  vec_t vecs[12];

  vid_hcount #(
    .WIDTH      (11),
    .PERIOD_RST (11'h7FF)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .per_wr_i (per_wr),
    .hss_wr_i (hss_wr),
    .hse_wr_i (hse_wr),
    .wr_d_i   (wr_d),
    .count_o  (count),
    .tc_o     (tc),
    .hsync_o  (hsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_tc = 0; m_hsync = 0;
    m_per = 2047; m_hss = 0; m_hse = 0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; per_wr = 1'b0; hss_wr = 1'b0; hse_wr = 1'b0; wr_d = '0;
  endtask

  // Advance one clock, update model from pre-edge inputs, compare #1 after edge.
  task automatic step(input string tag);
    int nc, nt, nh;
    @(posedge clk);
    nc = m_count; nt = 0; nh = m_hsync;
    if (en) begin
      if (m_count == m_per) begin nc = 0; nt = 1; end
      else nc = (m_count + 1) % 2048;
      if (m_count == m_hss) nh = 1;
      else if (m_count == m_hse) nh = 0;
    end
    if (per_wr) m_per = int'(wr_d);
    if (hss_wr) m_hss = int'(wr_d);
    if (hse_wr) m_hse = int'(wr_d);
    m_count = nc; m_tc = nt; m_hsync = nh;
    #1;
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".tc"}, int'(tc), m_tc);
    check({tag, ".hsync"}, int'(hsync), m_hsync);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_count"}, int'(count), 0);
    check({tag, ".rst_tc"}, int'(tc), 0);
    check({tag, ".rst_hsync"}, int'(hsync), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_reg(input int which, input int val);
    idle_inputs();
    wr_d = 11'(val);
    per_wr = (which == 0); hss_wr = (which == 1); hse_wr = (which == 2);
    step("wr");
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check("reset.count", int'(count), 0);
    check("reset.tc", int'(tc), 0);
    check("reset.hsync", int'(hsync), 0);
    #9 rst_n = 1'b1;

    // Test 1: period=9 then free-run; hss=hse=0 makes hsync rise after count 0.
    vecs[0] = '{en: 1'b0, per_wr: 1'b1, wr_d: 11'd9, exp_count: 0, exp_tc: 0, exp_hsync: 0};
    for (int i = 1; i < 12; i++) begin
      vecs[i] = '{en: 1'b1, per_wr: 1'b0, wr_d: 11'd0,
                  exp_count: i % 10, exp_tc: (i == 10) ? 1 : 0, exp_hsync: 1};
    end
    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en; per_wr = vecs[i].per_wr; wr_d = vecs[i].wr_d;
      step("t1");
      check($sformatf("t1v%0d.count", i), int'(count), vecs[i].exp_count);
      check($sformatf("t1v%0d.tc", i), int'(tc), vecs[i].exp_tc);
      check($sformatf("t1v%0d.hsync", i), int'(hsync), vecs[i].exp_hsync);
    end
    en = 1'b1;
    for (int i = 0; i < 13; i++) step("t1run");
    idle_inputs();

    // Test 2: hsync window 3..6 with period 9.
    pulse_reset("t2");
    write_reg(0, 9); write_reg(1, 3); write_reg(2, 6);
    en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step("t2");
      if (m_count == 4) check("t2.rise", int'(hsync), 1);
      if (m_count == 7) check("t2.fall", int'(hsync), 0);
    end

    // Test 3: en 1,0,0,1 at count 9.
    while (m_count != 9) step("t3pre");
    en = 1'b0;
    step("t3hold0");
    check("t3.hold0", int'(count), 9);
    step("t3hold1");
    check("t3.hold1", int'(count), 9);
    check("t3.notc", int'(tc), 0);
    en = 1'b1;
    step("t3wrap");
    check("t3.wrap", int'(count), 0);
    check("t3.tc", int'(tc), 1);
    step("t3after");
    check("t3.tc_once", int'(tc), 0);

    // Test 4: count at 500, period lowered to 100 -> wrap without tc first.
    pulse_reset("t4");
    en = 1'b1;
    for (int i = 0; i < 500; i++) step("t4run");
    check("t4.at500", int'(count), 500);
    wr_d = 11'd100; per_wr = 1'b1;
    step("t4wr");
    per_wr = 1'b0;
    for (int i = 0; i < 3000 && m_count != 0; i++) step("t4up");
    check("t4.wrap_count", int'(count), 0);
    check("t4.wrap_notc", int'(tc), 0);
    for (int i = 0; i < 101; i++) step("t4line");
    check("t4.tc_count", int'(count), 0);
    check("t4.tc", int'(tc), 1);

    // Test 5a: hss == hse == 5 -> rises at count 6, never falls.
    idle_inputs();
    pulse_reset("t5");
    write_reg(1, 5); write_reg(2, 5); write_reg(0, 12);
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step("t5a");
      if (i >= 6) check("t5a.stuck", int'(hsync), 1);
    end
    // Test 5b: period=0 -> count pinned at 0, tc every cycle.
    idle_inputs();
    pulse_reset("t5b");
    write_reg(0, 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("t5b");
      check("t5b.count", int'(count), 0);
      check("t5b.tc", int'(tc), 1);
    end

    // Test 6: mid-line reset restores period 2047.
    idle_inputs();
    write_reg(0, 20);
    en = 1'b1;
    for (int i = 0; i < 7; i++) step("t6pre");
    pulse_reset("t6");
    en = 1'b1;
    for (int i = 0; i < 2047; i++) begin
      step("t6run");
      if (i == 20) check("t6.no_tc_at_old_period", int'(tc), 0);
    end
    check("t6.top", int'(count), 2047);
    step("t6wrap");
    check("t6.wrap_tc", int'(tc), 1);

    // Randomized traffic against the model.
    idle_inputs();
    pulse_reset("rnd");
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      per_wr = ($urandom_range(0, 40) == 0);
      hss_wr = ($urandom_range(0, 30) == 0);
      hse_wr = ($urandom_range(0, 30) == 0);
      wr_d = 11'($urandom_range(0, 24));
      step("rnd");
      if (i == 700) pulse_reset("rndmid");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
